// File: rtl/uart_cmd_pkg.sv
// Shared types and byte constants for the UART command controller.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StGetData,
    StDoWrite,
    StDoRead,
    StSend,
    StWaitTx
  } state_e;

  localparam logic [7:0] HDR_WR  = 8'hA5;
  localparam logic [7:0] HDR_RD  = 8'h5A;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  // An address byte is in range when every bit above the register address field is zero.
  function automatic logic addr_valid(input logic [7:0] addr, input int unsigned addr_w);
    return (addr >> addr_w) == 8'h00;
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout counter; only instantiated when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_timeout
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic sys_rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cnt <= '0;
    end else if (clear_i) begin
      r_cnt <= '0;
    end else if (enable_i && (r_cnt != CntMax)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired_o = enable_i && (r_cnt == CntMax);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Byte-level host command parser driving a register bus and one response byte per frame.
// Optional inter-byte timeout is enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_done_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_wr_o,
  input  logic              tx_done_i,
  output logic              reg_we_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [7:0]        reg_wdata_o,
  input  logic [7:0]        reg_rdata_i,
  output logic              busy_o,
  output logic              err_o,
  input  logic              err_clr_i
);

  state_e            r_state;
  logic              r_is_wr;
  logic [7:0]        r_addr_byte;
  logic [7:0]        r_tx_data;
  logic              r_tx_wr;
  logic              r_reg_we;
  logic [ADDR_W-1:0] r_reg_addr;
  logic [7:0]        r_reg_wdata;
  logic              r_err;

  logic w_overrun;
  logic w_tmo_expired;

  // Bytes arriving while a frame is being executed or answered are lost.
  assign w_overrun = rx_done_i && (r_state inside {StDoWrite, StDoRead, StSend, StWaitTx});

`ifdef UART_CMD_TIMEOUT_EN
  logic w_tmo_en;
  assign w_tmo_en = (r_state == StGetAddr) || (r_state == StGetData);

  uart_cmd_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk      (clk),
    .sys_rst  (sys_rst),
    .clear_i  (rx_done_i || !w_tmo_en),
    .enable_i (w_tmo_en),
    .expired_o(w_tmo_expired)
  );
`else
  // Without the timeout feature TIMEOUT_CYC has no effect.
  assign w_tmo_expired = 1'b0 && (TIMEOUT_CYC == 0);
`endif

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state     <= StIdle;
      r_is_wr     <= 1'b0;
      r_addr_byte <= 8'h00;
      r_tx_data   <= 8'h00;
      r_tx_wr     <= 1'b0;
      r_reg_we    <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= 8'h00;
      r_err       <= 1'b0;
    end else begin
      r_tx_wr  <= 1'b0;
      r_reg_we <= 1'b0;

      if (w_overrun) begin
        r_err <= 1'b1;
      end else if (err_clr_i) begin
        r_err <= 1'b0;
      end

      unique case (r_state)
        StIdle: begin
          if (rx_done_i && ((rx_data_i == HDR_WR) || (rx_data_i == HDR_RD))) begin
            r_is_wr <= (rx_data_i == HDR_WR);
            r_state <= StGetAddr;
          end
        end

        StGetAddr: begin
          if (rx_done_i) begin
            r_addr_byte <= rx_data_i;
            if (r_is_wr) begin
              r_state <= StGetData;
            end else if (addr_valid(rx_data_i, ADDR_W)) begin
              r_reg_addr <= rx_data_i[ADDR_W-1:0];
              r_state    <= StDoRead;
            end else begin
              r_tx_data <= RSP_NAK;
              r_tx_wr   <= 1'b1;
              r_state   <= StSend;
            end
          end else if (w_tmo_expired) begin
            r_state <= StIdle;
          end
        end

        StGetData: begin
          if (rx_done_i) begin
            if (addr_valid(r_addr_byte, ADDR_W)) begin
              r_reg_addr  <= r_addr_byte[ADDR_W-1:0];
              r_reg_wdata <= rx_data_i;
              r_reg_we    <= 1'b1;
              r_state     <= StDoWrite;
            end else begin
              r_tx_data <= RSP_NAK;
              r_tx_wr   <= 1'b1;
              r_state   <= StSend;
            end
          end else if (w_tmo_expired) begin
            r_state <= StIdle;
          end
        end

        StDoWrite: begin
          r_tx_data <= RSP_ACK;
          r_tx_wr   <= 1'b1;
          r_state   <= StSend;
        end

        StDoRead: begin
          r_tx_data <= reg_rdata_i;
          r_tx_wr   <= 1'b1;
          r_state   <= StSend;
        end

        StSend: begin
          r_state <= StWaitTx;
        end

        StWaitTx: begin
          if (tx_done_i) begin
            r_state <= StIdle;
          end
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign tx_data_o   = r_tx_data;
  assign tx_wr_o     = r_tx_wr;
  assign reg_we_o    = r_reg_we;
  assign reg_addr_o  = r_reg_addr;
  assign reg_wdata_o = r_reg_wdata;
  assign busy_o      = (r_state != StIdle);
  assign err_o       = r_err;

endmodule
